gobou_ctrl_wb: RTL and testbench
================================

GOBOU_CTRL_WB -- requirements
Module: gobou_ctrl_wb

Interface
REQ-001 Parameter DWIDTH, default 16: data word width, signed.
REQ-002 Parameter AWIDTH, default 12: output-memory address width.
REQ-003 Parameter LWIDTH, default 10: output-count width.
REQ-004 clk  input  1  sole clock, all state on posedge.
REQ-005 xrst  input  1  reset, synchronous, active-low.
REQ-006 in_ctrl  input  ctrl_reg (start, valid, stop)  control bundle issued by the ReLU stage.
REQ-007 in_data  input  DWIDTH  ReLU output word, qualified by in_ctrl.valid.
REQ-008 out_base  input  AWIDTH  first write address, sampled on accepted start.
REQ-009 out_size  input  LWIDTH  expected word count, sampled on accepted start.
REQ-010 mem_we  output  1  output-memory write enable.
REQ-011 mem_addr  output  AWIDTH  output-memory write address.
REQ-012 mem_wdata  output  DWIDTH  output-memory write data.
REQ-013 busy  output  1  high from the cycle after an accepted start until the cycle after done.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 FSM states: S_IDLE, S_WRITE, S_DONE.
REQ-016 S_IDLE + in_ctrl.start -> S_WRITE; base and size latched, count cleared to 0.
- In all other states start is ignored.
REQ-017 In S_WRITE, in_ctrl.valid accepts in_data.
- Exactly one cycle later: mem_we=1, mem_addr=base+count (mod 2^AWIDTH), mem_wdata=in_data.
- count then increments.
REQ-018 Back-to-back valids produce back-to-back writes at consecutive addresses, with no bubbles.
REQ-019 S_WRITE + in_ctrl.stop -> S_DONE.
- If valid is high in the same cycle, that word is written as the last word.
REQ-020 S_DONE lasts exactly one cycle, asserts done=1, then returns to S_IDLE.
REQ-021 valid and stop are ignored in S_IDLE and S_DONE.
REQ-022 mem_we=0 whenever no accepted valid occurred in the previous cycle; mem_addr and mem_wdata hold their last values.
REQ-023 Address arithmetic wraps modulo 2^AWIDTH, with no error indication.
REQ-024 count saturates at 2^LWIDTH-1.

Reset
REQ-025 When xrst=0 at a posedge:
- state becomes S_IDLE;
- count, base, size, mem_addr, mem_wdata become 0;
- mem_we, busy, done become 0.
REQ-026 Reset mid-transfer aborts the transfer: no further writes, and no done pulse.

Configuration
REQ-027 Macro GOBOU_WB_OVERRUN_EN defined: adds output overrun (1 bit), cleared on accepted start and on reset.
- A valid accepted when count==size sets overrun, and overrun stays set (sticky).
- That word's write is suppressed (mem_we stays 0).
REQ-028 Macro not defined: no overrun port; every accepted valid is written, regardless of size.

Structure
REQ-029 The shared package gobou_pkg holds:
- ctrl_reg typedef (start, valid, stop);
- state enum;
- DWIDTH, AWIDTH, LWIDTH defaults.
REQ-030 Single flat module; no sub-modules.

Verification
REQ-031 Scenario 1, normal transfer:
- stimulus: base=0x100, size=4, start, 4 valids with data 1,2,3,4, then stop;
- response: writes to 0x100..0x103 each one cycle after its valid; done pulse one cycle after stop.
REQ-032 Scenario 2, gapped input with stop and valid together:
- stimulus: valids on cycles 0, 2, 5, with stop in the same cycle as the third valid;
- response: three writes at base+0, +1, +2; mem_we low between them; done on the next cycle.
REQ-033 Scenario 3, address wrap:
- stimulus: base=0xFFE, 4 valids;
- response: addresses 0xFFE, 0xFFF, 0x000, 0x001.
REQ-034 Scenario 4, overrun (macro defined):
- stimulus: size=2, 3 valids;
- response: two writes; third suppressed; overrun=1 until the next start.
REQ-035 Scenario 5, reset mid-transfer:
- stimulus: xrst=0 after 2 of 4 valids;
- response: all outputs 0 next cycle, no done pulse; a new start after reset works normally.
REQ-036 Scenario 6, ignored control:
- stimulus: start during S_WRITE, and valid in S_IDLE;
- response: no latch change and no write.

Source files
------------

// File: rtl/gobou_pkg.sv
// rtl/gobou_pkg.sv - shared control bundle, state encoding and default widths for gobou_ctrl_wb
package gobou_pkg;

   localparam int DEF_DWIDTH = 16;
   localparam int DEF_AWIDTH = 12;
   localparam int DEF_LWIDTH = 10;

   typedef struct packed {
      logic start;
      logic valid;
      logic stop;
   } ctrl_reg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/gobou_ctrl_wb.sv
// rtl/gobou_ctrl_wb.sv - write-back controller streaming ReLU words into output memory
// Optional macro GOBOU_WB_OVERRUN_EN adds a sticky overrun flag that drops words past out_size.
module gobou_ctrl_wb
   import gobou_pkg::*;
#(
   parameter int DWIDTH = DEF_DWIDTH,
   parameter int AWIDTH = DEF_AWIDTH,
   parameter int LWIDTH = DEF_LWIDTH
) (
   input  logic                     clk,
   input  logic                     xrst,
   input  ctrl_reg                  in_ctrl,
   input  logic signed [DWIDTH-1:0] in_data,
   input  logic [AWIDTH-1:0]        out_base,
   input  logic [LWIDTH-1:0]        out_size,
   output logic                     mem_we,
   output logic [AWIDTH-1:0]        mem_addr,
   output logic signed [DWIDTH-1:0] mem_wdata,
`ifdef GOBOU_WB_OVERRUN_EN
   output logic                     overrun,
`endif
   output logic                     busy,
   output logic                     done
);

   state_t            state;
   state_t            next_state;
   logic [AWIDTH-1:0] base;
   logic [LWIDTH-1:0] size;
   logic [LWIDTH-1:0] count;
   logic              accept;
   logic              write_ok;
   logic              take_start;

   assign accept     = (state == S_WRITE) && in_ctrl.valid;
   assign take_start = (state == S_IDLE) && in_ctrl.start;

`ifdef GOBOU_WB_OVERRUN_EN
   logic ovf_hit;
   assign ovf_hit  = accept && (count == size);
   assign write_ok = accept && !ovf_hit;
`else
   // size is still latched so the register map matches the overrun build
   logic size_unused;
   assign size_unused = ^size;
   assign write_ok    = accept;
`endif

   always_ff @(posedge clk) begin
      if (!xrst) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (in_ctrl.start) next_state = S_WRITE;
         S_WRITE: if (in_ctrl.stop)  next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE);
      done = (state == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (!xrst) begin
         base      <= '0;
         size      <= '0;
         count     <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= write_ok;
         if (take_start) begin
            base  <= out_base;
            size  <= out_size;
            count <= '0;
         end
         if (write_ok) begin
            mem_addr  <= base + AWIDTH'(count);
            mem_wdata <= in_data;
            if (count != '1) count <= count + 1'b1;
         end
      end
   end

`ifdef GOBOU_WB_OVERRUN_EN
   always_ff @(posedge clk) begin
      if (!xrst) begin
         overrun <= 1'b0;
      end else if (take_start) begin
         overrun <= 1'b0;
      end else if (ovf_hit) begin
         overrun <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_gobou_ctrl_wb.sv
// tb/tb_gobou_ctrl_wb.sv - scoreboard bench for gobou_ctrl_wb (honours GOBOU_WB_OVERRUN_EN)
module tb_gobou_ctrl_wb;
   import gobou_pkg::*;

   typedef struct {
      logic [11:0]        a;
      logic signed [15:0] d;
      int                 c;
   } wr_t;

   logic               clk = 1'b0;
   logic               xrst;
   ctrl_reg            ctrl;
   logic signed [15:0] in_data;
   logic [11:0]        out_base;
   logic [9:0]         out_size;
   logic               mem_we;
   logic [11:0]        mem_addr;
   logic signed [15:0] mem_wdata;
   logic               busy;
   logic               done;
`ifdef GOBOU_WB_OVERRUN_EN
   logic               overrun;
   logic               m_ovf;
`endif

   int          n_checks = 0;
   int          n_pass   = 0;
   int          cyc      = 0;
   wr_t         sb[$];
   logic [11:0] m_base;
   logic [9:0]  m_size;
   logic [9:0]  m_count;

   gobou_ctrl_wb dut (
      .clk       (clk),
      .xrst      (xrst),
      .in_ctrl   (ctrl),
      .in_data   (in_data),
      .out_base  (out_base),
      .out_size  (out_size),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
`ifdef GOBOU_WB_OVERRUN_EN
      .overrun   (overrun),
`endif
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (sb.size() == 0) begin
            check("spurious_write", 32'(mem_addr), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = sb.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(e.a));
            check("wr_data", 32'(mem_wdata), 32'(e.d));
            check("wr_cycle", cyc, e.c);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_xfer(input logic [11:0] b, input logic [9:0] s);
      out_base   = b;
      out_size   = s;
      ctrl.start = 1'b1;
      step();
      ctrl.start = 1'b0;
      m_base     = b;
      m_size     = s;
      m_count    = '0;
`ifdef GOBOU_WB_OVERRUN_EN
      m_ovf      = 1'b0;
`endif
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   // drive one valid word; with_stop closes the transfer in the same cycle
   task automatic send(input logic signed [15:0] d, input logic with_stop);
      wr_t e;
      ctrl.valid = 1'b1;
      ctrl.stop  = with_stop;
      in_data    = d;
`ifdef GOBOU_WB_OVERRUN_EN
      if (m_count == m_size) begin
         m_ovf = 1'b1;
      end else begin
`else
      begin
`endif
         e.a = m_base + 12'(m_count);
         e.d = d;
         e.c = cyc + 1;
         sb.push_back(e);
         m_count = m_count + 1'b1;
      end
      step();
      ctrl.valid = 1'b0;
      ctrl.stop  = 1'b0;
   endtask

   task automatic finish_xfer(input string tag);
      ctrl.stop = 1'b1;
      step();
      ctrl.stop = 1'b0;
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
      step();
      check({tag, "_done_clear"}, 32'(done), 32'd0);
      check({tag, "_busy_clear"}, 32'(busy), 32'd0);
      check({tag, "_drained"}, sb.size(), 0);
   endtask

   initial begin
      xrst     = 1'b0;
      ctrl     = '0;
      in_data  = '0;
      out_base = 12'h7FF;
      out_size = 10'd5;
      step();
      step();
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      xrst = 1'b1;
      step();

      // normal transfer, back-to-back valids
      start_xfer(12'h100, 10'd4);
      for (int i = 1; i <= 4; i++) send(16'(i), 1'b0);
      finish_xfer("normal");

      // gapped valids at cycles 0, 2, 5; stop with the last one
      start_xfer(12'h180, 10'd3);
      send(-16'sd7, 1'b0);
      step();
      send(16'sh1234, 1'b0);
      step();
      step();
      send(16'sh0030, 1'b1);
      check("gap_done", 32'(done), 32'd1);
      step();
      check("gap_done_clear", 32'(done), 32'd0);
      check("gap_drained", sb.size(), 0);

      // address wrap
      start_xfer(12'hFFE, 10'd4);
      for (int i = 0; i < 4; i++) send(16'(16'h0A0 + i), 1'b0);
      finish_xfer("wrap");

      // more valids than size
      start_xfer(12'h200, 10'd2);
      for (int i = 0; i < 3; i++) send(16'(16'h50 + i), 1'b0);
      step();
`ifdef GOBOU_WB_OVERRUN_EN
      check("ovf_set", 32'(overrun), 32'(m_ovf));
`endif
      finish_xfer("size");
`ifdef GOBOU_WB_OVERRUN_EN
      check("ovf_sticky", 32'(overrun), 32'd1);
`endif

      // start during S_WRITE is ignored: base stays
      start_xfer(12'h500, 10'd4);
`ifdef GOBOU_WB_OVERRUN_EN
      check("ovf_cleared", 32'(overrun), 32'd0);
`endif
      send(16'sd1, 1'b0);
      out_base   = 12'h7AA;
      out_size   = 10'd1;
      ctrl.start = 1'b1;
      step();
      ctrl.start = 1'b0;
      send(16'sd2, 1'b0);
      send(16'sd3, 1'b0);
      finish_xfer("ign_start");

      // valid and stop in S_IDLE are ignored
      ctrl.valid = 1'b1;
      ctrl.stop  = 1'b1;
      in_data    = 16'sh7777;
      step();
      ctrl.valid = 1'b0;
      ctrl.stop  = 1'b0;
      step();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_we", 32'(mem_we), 32'd0);

      // reset mid-transfer
      start_xfer(12'h300, 10'd4);
      send(16'sd11, 1'b0);
      send(16'sd12, 1'b0);
      xrst = 1'b0;
      ctrl.valid = 1'b1;
      in_data    = 16'sd13;
      step();
      ctrl.valid = 1'b0;
      check("mid_rst_we", 32'(mem_we), 32'd0);
      check("mid_rst_addr", 32'(mem_addr), 32'd0);
      check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
`ifdef GOBOU_WB_OVERRUN_EN
      check("mid_rst_ovf", 32'(overrun), 32'd0);
`endif
      xrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_no_done", 32'(done), 32'd0);
      end
      start_xfer(12'h040, 10'd2);
      send(16'sd21, 1'b0);
      send(16'sd22, 1'b0);
      finish_xfer("after_rst");

      step();
      step();
      check("final_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
